// File: rtl/imem_arbiter.sv
// Two-master arbiter in front of the combinational-read instruction ROM, with a
// one-word response buffer. Define IMEM_ARB_RR_EN for round-robin ties (default: m0 wins).
module imem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_valid,
   output logic              m0_req_ready,
   input  logic [ADDR_W-1:0] m0_req_addr,
   output logic              m0_rsp_valid,
   input  logic              m0_rsp_ready,
   output logic [DATA_W-1:0] m0_rsp_data,
   output logic              m0_rsp_err,
   input  logic              m1_req_valid,
   output logic              m1_req_ready,
   input  logic [ADDR_W-1:0] m1_req_addr,
   output logic              m1_rsp_valid,
   input  logic              m1_rsp_ready,
   output logic [DATA_W-1:0] m1_rsp_data,
   output logic              m1_rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata
);

   // state | meaning
   // IDLE  | response buffer empty
   // RESP  | buffer holds one word for requester own_q
   typedef enum logic {IDLE, RESP} state_t;

   state_t              state_q, state_d;
   logic                own_q, own_d;
   logic [DATA_W-1:0]   data_q;
   logic                err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                accept, gnt0, gnt1, tie_m1, own_ready;

`ifdef IMEM_ARB_RR_EN
   logic last_q;

   // reset to 1 so the first tie goes to m0
   always_ff @(posedge clk or posedge rst) begin
      if (rst)               last_q <= 1'b1;
      else if (gnt0 || gnt1) last_q <= gnt1;
   end

   assign tie_m1 = ~last_q;
`else
   assign tie_m1 = 1'b0;
`endif

   assign own_ready = own_q ? m1_rsp_ready : m0_rsp_ready;

   always_comb begin
      state_d  = state_q;
      own_d    = own_q;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      mem_addr = addr_q;
      // a full buffer may be drained and refilled in the same cycle
      accept   = (state_q == IDLE) || own_ready;
      if (accept) begin
         if (m0_req_valid && m1_req_valid) begin
            gnt1 = tie_m1;
            gnt0 = ~tie_m1;
         end else begin
            gnt0 = m0_req_valid;
            gnt1 = m1_req_valid;
         end
      end
      if (gnt1)      mem_addr = m1_req_addr;
      else if (gnt0) mem_addr = m0_req_addr;
      if (gnt0 || gnt1) begin
         state_d = RESP;
         own_d   = gnt1;
      end else if (state_q == RESP && own_ready) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         own_q   <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         if (gnt0 || gnt1) begin
            data_q <= mem_rdata;
            err_q  <= (mem_addr[1:0] != 2'b00);
            addr_q <= mem_addr;
         end
      end
   end

   assign m0_req_ready = gnt0;
   assign m1_req_ready = gnt1;
   assign m0_rsp_valid = (state_q == RESP) && !own_q;
   assign m1_rsp_valid = (state_q == RESP) && own_q;
   assign m0_rsp_data  = data_q;
   assign m1_rsp_data  = data_q;
   assign m0_rsp_err   = err_q;
   assign m1_rsp_err   = err_q;

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-requester arbiter that shares the single-ported, combinational-read instruction ROM between the fetch unit (m0) and a second reader (m1: loader/debug/LSU constant reads). It accepts one valid/ready request per grant, drives the ROM address, captures the read word into a response buffer, and returns it on a per-requester valid/ready response channel. It sits between the IFU/secondary master and `inst_rom` in the NPC core.

## Interface
- ADDR_W, 32, byte address width of requests
- DATA_W, 32, instruction word width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req_valid  in  1  fetch request valid
- m0_req_ready  out  1  arbiter accepts m0 request this cycle
- m0_req_addr  in  ADDR_W  fetch byte address
- m0_rsp_valid  out  1  response for m0 valid
- m0_rsp_ready  in  1  m0 consumes response
- m0_rsp_data  out  DATA_W  returned word
- m0_rsp_err  out  1  request address was misaligned
- m1_req_valid / m1_req_ready / m1_req_addr / m1_rsp_valid / m1_rsp_ready / m1_rsp_data / m1_rsp_err: same as m0, for requester 1
- mem_addr  out  ADDR_W  byte address driven to ROM (combinational from selected request)
- mem_rdata  in  DATA_W  ROM read data, combinational from mem_addr

## Operation
- States: IDLE (response buffer empty), RESP (buffer holds one word for owner `own`).
- Accept condition: buffer empty, or buffer full and owner's rsp_ready=1 this cycle (drain and refill same cycle).
- Arbitration when accept condition holds: only one valid -> grant it; both valid -> grant per priority policy (see Configuration). Exactly one req_ready high per cycle, only for granted master; neither high otherwise.
- On grant: mem_addr = granted req_addr; on rising edge buffer <= mem_rdata, err <= (req_addr[1:0] != 0), own <= granted id, state <= RESP. Misaligned request still reads ROM; data is don't-care, err=1.
- No grant: mem_addr holds last granted address (no toggling).
- RESP: rsp_valid high only for `own`; data/err stable until owner's rsp_ready. Handshake without new grant -> IDLE.
- Non-owner's rsp_valid is 0; its requests wait (req_ready=0) until accept condition.
- Round-robin pointer `last` updated only on grant, to granted id.
- rsp_ready asserted while rsp_valid=0 is ignored.

## Timing
- Reset (async, immediate): state=IDLE, all req_ready=0 until first clk edge only if combinational path would otherwise assert — req_ready is combinational and valid from reset deassertion; rsp_valid=0, rsp_data=0, rsp_err=0, mem_addr=0, last=1 (so m0 wins first tie).
- Latency: request handshake at cycle N -> rsp_valid at N+1.
- Throughput: one transaction per cycle with rsp_ready held high; grant alternates under contention.
- Reset mid-transaction drops buffered response; no partial response is issued afterwards.
- req_ready depends combinationally on req_valid and owner's rsp_ready; req_valid must not depend on req_ready.

## Configuration
- IMEM_ARB_RR_EN defined: tie between m0 and m1 goes to the master not equal to `last` (round-robin, starvation-free).
- Undefined: fixed priority, m0 always wins ties; `last` register omitted; m1 served only when m0_req_valid=0 at accept time.

## Test plan
- Single m0 read: rom[0x10>>2]=0x00500313, m0 req addr 0x10 at cycle 1 -> m0_req_ready=1 cycle 1, m0_rsp_valid=1 data 0x00500313 err=0 cycle 2; m1_rsp_valid stays 0.
- Contention, RR build: both valid every cycle, addrs 0x0/0x4, rsp_ready=1 -> grants m0,m1,m0,m1 on consecutive cycles, one response per cycle, correct data per owner; fixed build -> m0 every cycle, m1_req_ready never 1.
- Backpressure: m0 response held with m0_rsp_ready=0 for 3 cycles while m1 valid -> m0 data stable, m1_req_ready=0 all 3 cycles; on release m1 granted same cycle, m1_rsp_valid next cycle.
- Misaligned: m1 addr 0x6 -> m1_rsp_valid next cycle with m1_rsp_err=1.
- Async reset while in RESP (rsp_ready=0): rst pulse between edges -> rsp_valid drops to 0 immediately, no stale response after release; first tie grants m0.
